mem_bus_interface: RTL and testbench

Multiplexed external-memory bus master for the 8-bit CPU, sitting directly downstream of the controller/datapath. It accepts one read or write request at a time, using the memory address, write data and the controller's write-request strobe. It runs the request on the shared 8-bit bidirectional pin bus as address-low, address-high and data phases. It holds the core in a stall (`busy`) until the access completes, then returns read data.

---
 rtl/mem_bus_interface.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_bus_interface.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_interface.sv
// mem_bus_interface
// Multiplexed external-memory bus master for the 8-bit CPU. One read or write
// is accepted at a time. It runs on the shared 8-bit pin bus as address-low,
// address-high and data phases, and stalls the core with busy until the access
// completes.
//
// Optional feature: define MEM_BUS_ADDR_CACHE_EN to remember the last high
// address byte driven on the bus. An access whose high byte matches the cached
// byte skips the ADDR_HI phase.
//
// Every pin-side output is a flop. The output decoder works from the *next*
// state, so each pin takes its phase value on the same edge that enters the
// phase.

module mem_bus_interface #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  readReq,
  input  logic                  writeReq,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_WIDTH-1:0] busIn,
  output logic [DATA_WIDTH-1:0] busOut,
  output logic                  busOe,
  output logic                  aleLo,
  output logic                  aleHi,
  output logic                  memWeN,
  output logic                  memOeN
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_LO = 3'd1,
    ADDR_HI = 3'd2,
    DATA    = 3'd3,
    DONE    = 3'd4
  } stateT;

  // Load value for the data-phase down-counter (legal WAIT_CYCLES is 0..7).
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

  stateT                 state;
  stateT                 nextState;
  logic [2:0]            cnt;
  logic [2:0]            cntNxt;

  // Request context captured at the accept edge.
  logic [7:0]            addrHiQ;
  logic [DATA_WIDTH-1:0] wdataQ;
  logic                  isWriteQ;

  // Registered-output next values.
  logic [DATA_WIDTH-1:0] busOutNxt;
  logic                  busOeNxt;
  logic                  aleLoNxt;
  logic                  aleHiNxt;
  logic                  memWeNNxt;
  logic                  memOeNNxt;
  logic                  busyNxt;
  logic                  doneNxt;

  logic                  accept;
  logic                  lastData;
  logic                  skipHi;

  assign accept   = (state == IDLE) && (readReq || writeReq);
  assign lastData = (state == DATA) && (cnt == 3'd0);

`ifdef MEM_BUS_ADDR_CACHE_EN
  logic [7:0] hiCache;
  logic       hiValid;
  logic       hitQ;

  // High-byte cache: filled when an ADDR_HI phase completes. The hit decision
  // is taken at accept time against the incoming address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hiCache <= 8'h00;
      hiValid <= 1'b0;
      hitQ    <= 1'b0;
    end else begin
      if (accept) begin
        hitQ <= hiValid && (addr[15:8] == hiCache);
      end
      if (state == ADDR_HI) begin
        hiCache <= addrHiQ;
        hiValid <= 1'b1;
      end
    end
  end

  assign skipHi = hitQ;
`else
  assign skipHi = 1'b0;
`endif

  // State register and data-phase counter.
  // NOTE: sequential state uses non-blocking (<=) so that every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= nextState;
      cnt   <= cntNxt;
    end
  end

  // Next-state logic and counter load/decrement.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    cntNxt    = cnt;
    unique case (state)
      IDLE:    if (accept) nextState = ADDR_LO;
      ADDR_LO: nextState = skipHi ? DATA : ADDR_HI;
      ADDR_HI: nextState = DATA;
      DATA:    if (cnt == 3'd0) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (nextState == DATA && state != DATA) begin
      cntNxt = WAIT_LOAD;
    end else if (state == DATA && cnt != 3'd0) begin
      cntNxt = cnt - 3'd1;
    end
  end

  // Output decode from the next state. ADDR_LO is entered only from the
  // accept edge, so it drives the live address input. Later phases use the
  // latched context.
  always_comb begin
    busOutNxt = '0;
    busOeNxt  = 1'b0;
    aleLoNxt  = 1'b0;
    aleHiNxt  = 1'b0;
    memWeNNxt = 1'b1;
    memOeNNxt = 1'b1;
    busyNxt   = (nextState != IDLE);
    doneNxt   = (nextState == DONE);
    unique case (nextState)
      ADDR_LO: begin
        busOutNxt = addr[7:0];
        busOeNxt  = 1'b1;
        aleLoNxt  = 1'b1;
      end
      ADDR_HI: begin
        busOutNxt = addrHiQ;
        busOeNxt  = 1'b1;
        aleHiNxt  = 1'b1;
      end
      DATA: begin
        if (isWriteQ) begin
          busOutNxt = wdataQ;
          busOeNxt  = 1'b1;
          memWeNNxt = 1'b0;
        end else begin
          memOeNNxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Request capture at accept. When both requests are high, the write wins.
  // NOTE: the context registers are reset too. They are only a few flops, and
  // a known value after reset keeps the bus deterministic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrHiQ  <= 8'h00;
      wdataQ   <= '0;
      isWriteQ <= 1'b0;
    end else if (accept) begin
      addrHiQ  <= addr[15:8];
      wdataQ   <= wdata;
      isWriteQ <= writeReq;
    end
  end

  // Pin-side and core-side output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busOut <= '0;
      busOe  <= 1'b0;
      aleLo  <= 1'b0;
      aleHi  <= 1'b0;
      memWeN <= 1'b1;
      memOeN <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busOut <= busOutNxt;
      busOe  <= busOeNxt;
      aleLo  <= aleLoNxt;
      aleHi  <= aleHiNxt;
      memWeN <= memWeNNxt;
      memOeN <= memOeNNxt;
      busy   <= busyNxt;
      done   <= doneNxt;
    end
  end

  // Read data sampled from the pins at the edge that ends the last read DATA
  // cycle. It is held through writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (lastData && !isWriteQ) begin
      rdata <= busIn;
    end
  end

endmodule

// File: tb/tb_mem_bus_interface.sv
// tb_mem_bus_interface
// Directed bench for mem_bus_interface. u0 uses WAIT_CYCLES = 1 and u1 uses
// WAIT_CYCLES = 0. The cache-hit sequence runs only when MEM_BUS_ADDR_CACHE_EN
// is defined.

module tb_mem_bus_interface;

  logic        clk = 1'b0;
  logic        reset;

  logic        readReq, writeReq;
  logic [15:0] addr;
  logic [7:0]  wdata, busIn;
  logic [7:0]  rdata, busOut;
  logic        busy, done, busOe, aleLo, aleHi, memWeN, memOeN;

  logic        readReq1, writeReq1;
  logic [15:0] addr1;
  logic [7:0]  wdata1, busIn1;
  logic [7:0]  rdata1, busOut1;
  logic        busy1, done1, busOe1, aleLo1, aleHi1, memWeN1, memOeN1;

  int tests  = 0;
  int failed = 0;

  mem_bus_interface #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_CYCLES(1)) u0 (
    .clk(clk), .reset(reset), .readReq(readReq), .writeReq(writeReq),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .busIn(busIn), .busOut(busOut), .busOe(busOe), .aleLo(aleLo),
    .aleHi(aleHi), .memWeN(memWeN), .memOeN(memOeN)
  );

  mem_bus_interface #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .reset(reset), .readReq(readReq1), .writeReq(writeReq1),
    .addr(addr1), .wdata(wdata1), .rdata(rdata1), .busy(busy1), .done(done1),
    .busIn(busIn1), .busOut(busOut1), .busOe(busOe1), .aleLo(aleLo1),
    .aleHi(aleHi1), .memWeN(memWeN1), .memOeN(memOeN1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one u0 access and checks every cycle from E0 through E0+expDone+1.
  // k is the cycle index after the accept edge E0.
  task automatic access(input logic wr, input logic rd, input logic [15:0] a,
                        input logic [7:0] d, input logic [7:0] bin,
                        input int expDone, input logic expHi,
                        input logic [7:0] expRdata, input logic pulseRd);
    int  dataStart;
    logic inData;
    dataStart = expHi ? 2 : 1;
    writeReq  = wr;
    readReq   = rd;
    addr      = a;
    wdata     = d;
    busIn     = bin;
    step();
    writeReq = 1'b0;
    readReq  = 1'b0;
    addr     = 16'hFFFF;
    wdata    = 8'h00;
    for (int k = 0; k <= expDone + 1; k++) begin
      inData = (k >= dataStart) && (k < expDone);
      check($sformatf("busy[%0d]", k),   busy,   k <= expDone);
      check($sformatf("done[%0d]", k),   done,   k == expDone);
      check($sformatf("aleLo[%0d]", k),  aleLo,  k == 0);
      check($sformatf("aleHi[%0d]", k),  aleHi,  expHi && (k == 1));
      check($sformatf("memWeN[%0d]", k), memWeN, !(inData && wr));
      check($sformatf("memOeN[%0d]", k), memOeN, !(inData && !wr));
      check($sformatf("busOe[%0d]", k),  busOe,
            (k == 0) || (expHi && k == 1) || (inData && wr));
      if (k == 0)           check("busOutLo", busOut, a[7:0]);
      if (expHi && k == 1)  check("busOutHi", busOut, a[15:8]);
      if (inData && wr)     check($sformatf("busOutData[%0d]", k), busOut, d);
      if (k == expDone)     check("rdata", rdata, expRdata);
      readReq = pulseRd && (k == 0);
      if (k <= expDone) step();
    end
    readReq = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    readReq = 0; writeReq = 0; addr = 0; wdata = 0; busIn = 0;
    readReq1 = 0; writeReq1 = 0; addr1 = 0; wdata1 = 0; busIn1 = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_busOut", busOut, 8'h00);
    check("rst_busOe", busOe, 0);
    check("rst_ale", {aleLo, aleHi}, 2'b00);
    check("rst_strobes", {memWeN, memOeN}, 2'b11);
    step();
    step();
    reset = 1'b0;
    step();

    // Read 0x12A4 returning 0x5C: done at E0+4.
    access(1'b0, 1'b1, 16'h12A4, 8'h00, 8'h5C, 4, 1'b1, 8'h5C, 1'b0);
    step();
    // Write 0x0310 <= 0xE7: rdata stays 0x5C.
    access(1'b1, 1'b0, 16'h0310, 8'hE7, 8'hAA, 4, 1'b1, 8'h5C, 1'b0);
    step();
    // Both requests high: the write wins. A read pulse while busy is ignored.
    access(1'b1, 1'b1, 16'h7700, 8'h3C, 8'h99, 4, 1'b1, 8'h5C, 1'b1);
    check("noQueue_busy", busy, 0);
    check("noQueue_aleLo", aleLo, 0);
    step();

`ifdef MEM_BUS_ADDR_CACHE_EN
    access(1'b0, 1'b1, 16'h4401, 8'h00, 8'h11, 4, 1'b1, 8'h11, 1'b0);
    step();
    access(1'b0, 1'b1, 16'h4480, 8'h00, 8'h22, 3, 1'b0, 8'h22, 1'b0);
    step();
    access(1'b0, 1'b1, 16'h4580, 8'h00, 8'h33, 4, 1'b1, 8'h33, 1'b0);
    step();
`endif

    // Reset mid-access during ADDR_HI.
    readReq = 1'b1;
    addr    = 16'h9900;
    busIn   = 8'h44;
    step();
    readReq = 1'b0;
    step();
    check("mid_aleHi", aleHi, 1);
    reset = 1'b1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_rdata", rdata, 8'h00);
    check("mid_busOe", busOe, 0);
    check("mid_busOut", busOut, 8'h00);
    check("mid_ale", {aleLo, aleHi}, 2'b00);
    check("mid_strobes", {memWeN, memOeN}, 2'b11);
    step();
    check("mid_doneHeld", done, 0);
    reset = 1'b0;
    step();
    check("post_done", done, 0);
    // After reset the cache is invalid, so ADDR_HI runs even for 0x45xx.
    access(1'b0, 1'b1, 16'h4580, 8'h00, 8'h66, 4, 1'b1, 8'h66, 1'b0);
    step();

    // WAIT_CYCLES = 0 instance: done at E0+3 and memOeN low for 1 cycle.
    readReq1 = 1'b1;
    addr1    = 16'h2233;
    busIn1   = 8'h77;
    step();
    readReq1 = 1'b0;
    addr1    = 16'h0000;
    check("w0_aleLo", aleLo1, 1);
    check("w0_busOutLo", busOut1, 8'h33);
    check("w0_oeN0", memOeN1, 1);
    step();
    check("w0_aleHi", aleHi1, 1);
    check("w0_busOutHi", busOut1, 8'h22);
    check("w0_oeN1", memOeN1, 1);
    step();
    check("w0_oeN2", memOeN1, 0);
    check("w0_busOe2", busOe1, 0);
    check("w0_done2", done1, 0);
    step();
    check("w0_done3", done1, 1);
    check("w0_oeN3", memOeN1, 1);
    check("w0_rdata", rdata1, 8'h77);
    step();
    check("w0_busy4", busy1, 0);
    check("w0_done4", done1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
